harness_frame_sequencer: RTL and testbench
==========================================

Name: harness_frame_sequencer

Overview:
- Frame-level scheduler between the UART byte receiver/transmitter and the accelerator under test in the high-throughput test harness.
- Buffers host bytes and forwards them to the accelerator as one terminator-delimited frame.
- Then grants the UART transmitter to the accelerator's output stream until that frame's last byte is sent.
- Owns frame sequencing only. Sticky error flags, frame count and the timeout let a hung accelerator be recovered without a reset.

Parameters:
DATA_WIDTH, 8, byte width on all streams
FIFO_DEPTH, 16, receive buffer entries, power of two, >= 2
MAX_FRAME_LENGTH, 64, maximum input beats per frame, terminator included
TERMINATOR, 8'h00, byte value that ends a host frame
TIMEOUT_CYCLES, 100000, idle clock cycles in RESPOND before abort

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
rx_data  input  DATA_WIDTH  byte from UART receiver
rx_valid  input  1  one-cycle strobe, no backpressure
acc_in_data  output  DATA_WIDTH  frame byte to accelerator
acc_in_valid  output  1  acc_in beat valid
acc_in_last  output  1  final beat of frame
acc_in_ready  input  1  accelerator accepts beat
acc_out_data  input  DATA_WIDTH  result byte from accelerator
acc_out_valid  input  1  result beat valid
acc_out_last  input  1  final result beat
acc_out_ready  output  1  result beat accepted
tx_data  output  DATA_WIDTH  byte to UART transmitter
tx_valid  output  1  byte valid
tx_ready  input  1  transmitter accepts byte
error_clear  input  1  one-cycle pulse, clears error flags
busy  output  1  state != IDLE
frame_count  output  16  completed frames, wraps at 2^16
error_overrun  output  1  sticky, rx byte dropped on full FIFO
error_length  output  1  sticky, frame truncated at MAX_FRAME_LENGTH
error_timeout  output  1  sticky, RESPOND aborted

Behaviour:
- Reset (reset=0):
  - Takes effect immediately, without waiting for a clock edge.
  - State = IDLE, FIFO empty, beat counter = 0, timeout counter = 0, frame_count = 0.
  - All flags = 0 and all valid/ready outputs = 0.
  - Reset asserted mid-frame discards the buffered bytes and the partial frame, with no further handshakes.
- FIFO:
  - Writes rx_data on every rx_valid in every state.
  - Full with no read in the same cycle: byte dropped, error_overrun set.
  - Full with a read in the same cycle: write accepted, occupancy unchanged.
  - Head byte is registered (first-word fall-through): acc_in_data = head whenever the FIFO is non-empty.
- States:
  - IDLE -> FORWARD when the FIFO is non-empty at the clock edge.
  - FORWARD:
    - acc_in_valid = FIFO non-empty.
    - acc_in_last = (head == TERMINATOR) or (beat counter == MAX_FRAME_LENGTH-1).
    - Each acc_in handshake pops the FIFO and increments the beat counter.
    - Last beat is truncated (not the terminator): set error_length.
    - Handshake with acc_in_last=1: beat counter -> 0, state -> RESPOND.
    - acc_in_valid is never withdrawn before acceptance; data stays stable while stalled.
  - RESPOND:
    - Combinational pass-through: tx_data = acc_out_data, tx_valid = acc_out_valid, acc_out_ready = tx_ready.
    - Timeout counter clears on each handshake, otherwise increments.
    - Handshake with acc_out_last=1: frame_count++, state -> IDLE.
    - Counter reaching TIMEOUT_CYCLES-1 without a handshake: error_timeout set, state -> IDLE, no frame_count increment.
    - If the final handshake and the timeout coincide, the handshake wins.
  - Outside RESPOND: tx_valid = 0, acc_out_ready = 0. Outside FORWARD: acc_in_valid = 0, acc_in_last = 0.
- Bytes arriving during RESPOND stay buffered and form the next frame.
- error_clear clears all three flags. If error_clear coincides with a new error event, the flag remains set.
- Latency: a byte strobed with an empty FIFO in IDLE is presented on acc_in two cycles later: one cycle to the FIFO head, one cycle for IDLE -> FORWARD.

Test Plan:
- Send 11 22 33 00 with acc_in_ready=1 -> four acc_in beats 11,22,33,00, last only on 00; state RESPOND; busy=1.
- In RESPOND, accelerator returns AA,BB (last on BB) with tx_ready toggling 1,0,1 -> tx sees AA then BB, no duplicates or drops; state IDLE; frame_count=1.
- Send 11 22 33 44, then 30 bytes of 01, then 00 (35 bytes total) with acc_in_ready=0 until the FIFO holds 16 -> error_overrun=1, dropped bytes absent from acc_in; error_clear -> 0.
- MAX_FRAME_LENGTH=4, send 01 02 03 04 05 00 -> first frame is 01..04 with last on 04, error_length=1; 05 00 retained as the next frame.
- TIMEOUT_CYCLES=50, no acc_out_valid after the frame -> IDLE after 50 cycles, error_timeout=1, frame_count unchanged.
- Reset asserted after two beats of a frame -> outputs 0 asynchronously; after release a fresh frame 7F 00 is forwarded correctly.

Source files
------------

// File: rtl/harness_frame_sequencer.sv
// Frame sequencer between the UART byte streams and the accelerator under test.
// Host bytes are buffered in a small FIFO and forwarded as one terminator-delimited
// frame. The UART transmitter is then granted to the accelerator's result stream
// until that frame's final result byte has been sent.
module harness_frame_sequencer #(
  parameter int unsigned           DATA_WIDTH       = 8,
  parameter int unsigned           FIFO_DEPTH       = 16,
  parameter int unsigned           MAX_FRAME_LENGTH = 64,
  parameter logic [DATA_WIDTH-1:0] TERMINATOR       = '0,
  parameter int unsigned           TIMEOUT_CYCLES   = 100000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  output logic [DATA_WIDTH-1:0] acc_in_data,
  output logic                  acc_in_valid,
  output logic                  acc_in_last,
  input  logic                  acc_in_ready,
  input  logic [DATA_WIDTH-1:0] acc_out_data,
  input  logic                  acc_out_valid,
  input  logic                  acc_out_last,
  output logic                  acc_out_ready,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  input  logic                  error_clear,
  output logic                  busy,
  output logic [15:0]           frame_count,
  output logic                  error_overrun,
  output logic                  error_length,
  output logic                  error_timeout
);

  localparam int unsigned PtrW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned BeatW = $clog2(MAX_FRAME_LENGTH + 1);
  localparam int unsigned TimeW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CntW-1:0]  FifoFull    = CntW'(FIFO_DEPTH);
  localparam logic [BeatW-1:0] BeatLastIdx = BeatW'(MAX_FRAME_LENGTH - 1);
  localparam logic [TimeW-1:0] TimeoutLast = TimeW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StForward, StRespond} state_e;

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]         count_q, count_d;
  logic [BeatW-1:0]        beat_q, beat_d;
  logic [TimeW-1:0]        idle_q, idle_d;
  logic [15:0]             frame_count_q, frame_count_d;
  logic                    err_ovr_q, err_ovr_d;
  logic                    err_len_q, err_len_d;
  logic                    err_to_q, err_to_d;

  logic                    fifo_empty, fifo_full;
  logic [DATA_WIDTH-1:0]   head;
  logic                    in_fwd, in_resp;
  logic                    pop, push, overrun_ev;
  logic                    out_hs, len_ev, to_ev;

  // Stream outputs and FIFO handshake decode.
  always_comb begin
    fifo_empty    = (count_q == '0);
    fifo_full     = (count_q == FifoFull);
    head          = mem_q[rd_ptr_q];
    in_fwd        = (state_q == StForward);
    in_resp       = (state_q == StRespond);

    acc_in_valid  = in_fwd && !fifo_empty;
    // Beat-limit truncation can raise last even while waiting for the next byte.
    acc_in_last   = in_fwd && ((beat_q == BeatLastIdx) || (!fifo_empty && (head == TERMINATOR)));
    acc_in_data   = fifo_empty ? '0 : head;

    tx_data       = in_resp ? acc_out_data : '0;
    tx_valid      = in_resp && acc_out_valid;
    acc_out_ready = in_resp && tx_ready;

    pop           = acc_in_valid && acc_in_ready;
    push          = rx_valid && (!fifo_full || pop);
    overrun_ev    = rx_valid && fifo_full && !pop;
    out_hs        = tx_valid && tx_ready;

    busy          = (state_q != StIdle);
    frame_count   = frame_count_q;
    error_overrun = err_ovr_q;
    error_length  = err_len_q;
    error_timeout = err_to_q;
  end

  // Next-state for FIFO pointers, frame FSM, counters and sticky flags.
  always_comb begin
    wr_ptr_d      = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d      = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d       = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    state_d       = state_q;
    beat_d        = beat_q;
    idle_d        = idle_q;
    frame_count_d = frame_count_q;
    len_ev        = 1'b0;
    to_ev         = 1'b0;

    case (state_q)
      StIdle: begin
        if (!fifo_empty) state_d = StForward;
      end
      StForward: begin
        if (pop) begin
          if (acc_in_last) begin
            len_ev  = (head != TERMINATOR);
            beat_d  = '0;
            state_d = StRespond;
          end else begin
            beat_d  = beat_q + 1'b1;
          end
        end
      end
      StRespond: begin
        // A final handshake wins over a coinciding timeout.
        if (out_hs) begin
          idle_d = '0;
          if (acc_out_last) begin
            frame_count_d = frame_count_q + 16'd1;
            state_d       = StIdle;
          end
        end else if (idle_q == TimeoutLast) begin
          idle_d  = '0;
          to_ev   = 1'b1;
          state_d = StIdle;
        end else begin
          idle_d  = idle_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // A new event in the same cycle as a clear keeps the flag set.
    err_ovr_d = (err_ovr_q && !error_clear) || overrun_ev;
    err_len_d = (err_len_q && !error_clear) || len_ev;
    err_to_d  = (err_to_q && !error_clear) || to_ev;
  end

  // Control state with asynchronous reset; reset discards any partial frame.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      beat_q        <= '0;
      idle_q        <= '0;
      frame_count_q <= '0;
      err_ovr_q     <= 1'b0;
      err_len_q     <= 1'b0;
      err_to_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      beat_q        <= beat_d;
      idle_q        <= idle_d;
      frame_count_q <= frame_count_d;
      err_ovr_q     <= err_ovr_d;
      err_len_q     <= err_len_d;
      err_to_q      <= err_to_d;
    end
  end

  // FIFO storage; contents are don't-care while the occupancy count says empty.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= rx_data;
  end

endmodule

// File: tb/tb_harness_frame_sequencer.sv
// Bench for harness_frame_sequencer: directed frames plus random traffic, every
// cycle compared against a queue-based behavioural model of the sequencer.
module tb_harness_frame_sequencer;

  localparam int DEPTH = 16;
  localparam int MAXF  = 4;
  localparam int TO    = 50;
  localparam logic [7:0] TERM = 8'h00;
  localparam int MIdle = 0, MFwd = 1, MResp = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic [7:0]  acc_in_data;
  logic        acc_in_valid, acc_in_last;
  logic        acc_in_ready = 1'b0;
  logic [7:0]  acc_out_data = '0;
  logic        acc_out_valid = 1'b0;
  logic        acc_out_last = 1'b0;
  logic        acc_out_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        error_clear = 1'b0;
  logic        busy;
  logic [15:0] frame_count;
  logic        error_overrun, error_length, error_timeout;

  harness_frame_sequencer #(
    .DATA_WIDTH       (8),
    .FIFO_DEPTH       (DEPTH),
    .MAX_FRAME_LENGTH (MAXF),
    .TERMINATOR       (TERM),
    .TIMEOUT_CYCLES   (TO)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .acc_in_data   (acc_in_data),
    .acc_in_valid  (acc_in_valid),
    .acc_in_last   (acc_in_last),
    .acc_in_ready  (acc_in_ready),
    .acc_out_data  (acc_out_data),
    .acc_out_valid (acc_out_valid),
    .acc_out_last  (acc_out_last),
    .acc_out_ready (acc_out_ready),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .error_clear   (error_clear),
    .busy          (busy),
    .frame_count   (frame_count),
    .error_overrun (error_overrun),
    .error_length  (error_length),
    .error_timeout (error_timeout)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state.
  logic [7:0] m_fifo [$];
  int         m_state, m_beats, m_idle, m_frames;
  bit         m_ovr, m_len, m_to;

  logic [8:0] obs_in [$];  // {last, data} of accepted acc_in beats
  logic [7:0] obs_tx [$];

  logic [8:0] exp1 [4] = '{9'h011, 9'h022, 9'h033, 9'h100};
  logic [8:0] exp3 [4] = '{9'h011, 9'h022, 9'h033, 9'h144};
  logic [8:0] exp4 [6] = '{9'h001, 9'h002, 9'h003, 9'h104, 9'h005, 9'h100};
  logic [8:0] exp6 [2] = '{9'h07F, 9'h100};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_fifo.delete();
    m_state  = MIdle;
    m_beats  = 0;
    m_idle   = 0;
    m_frames = 0;
    m_ovr    = 0;
    m_len    = 0;
    m_to     = 0;
  endtask

  function automatic bit exp_in_valid();
    return (m_state == MFwd) && (m_fifo.size() > 0);
  endfunction

  function automatic bit exp_in_last();
    return (m_state == MFwd) &&
           ((m_beats == MAXF - 1) || ((m_fifo.size() > 0) && (m_fifo[0] == TERM)));
  endfunction

  // Advance the model by one clock edge using the inputs applied this cycle.
  task automatic model_step();
    bit full, pop, ohs, last_now, ovr_ev, len_ev, to_ev;
    if (!reset) begin
      model_reset();
      return;
    end
    full     = (m_fifo.size() == DEPTH);
    last_now = exp_in_last();
    pop      = exp_in_valid() && acc_in_ready;
    ohs      = (m_state == MResp) && acc_out_valid && tx_ready;
    ovr_ev   = rx_valid && full && !pop;
    len_ev   = 0;
    to_ev    = 0;
    case (m_state)
      MIdle: if (m_fifo.size() > 0) m_state = MFwd;
      MFwd: begin
        if (pop) begin
          if (last_now) begin
            len_ev  = (m_fifo[0] != TERM);
            m_beats = 0;
            m_state = MResp;
          end else begin
            m_beats++;
          end
        end
      end
      default: begin
        if (ohs) begin
          m_idle = 0;
          if (acc_out_last) begin
            m_frames = (m_frames + 1) % 65536;
            m_state  = MIdle;
          end
        end else if (m_idle + 1 == TO) begin
          m_idle  = 0;
          to_ev   = 1;
          m_state = MIdle;
        end else begin
          m_idle++;
        end
      end
    endcase
    if (pop) void'(m_fifo.pop_front());
    if (rx_valid && !ovr_ev) m_fifo.push_back(rx_data);
    m_ovr = (m_ovr && !error_clear) || ovr_ev;
    m_len = (m_len && !error_clear) || len_ev;
    m_to  = (m_to && !error_clear) || to_ev;
  endtask

  task automatic compare_outputs();
    check_eq("busy", busy, m_state != MIdle);
    check_eq("in_valid", acc_in_valid, exp_in_valid());
    check_eq("in_last", acc_in_last, exp_in_last());
    if (exp_in_valid()) check_eq("in_data", acc_in_data, m_fifo[0]);
    check_eq("tx_valid", tx_valid, (m_state == MResp) && acc_out_valid);
    if ((m_state == MResp) && acc_out_valid) check_eq("tx_data", tx_data, acc_out_data);
    check_eq("out_ready", acc_out_ready, (m_state == MResp) && tx_ready);
    check_eq("frame_count", frame_count, m_frames);
    check_eq("err_ovr", error_overrun, m_ovr);
    check_eq("err_len", error_length, m_len);
    check_eq("err_to", error_timeout, m_to);
  endtask

  // One cycle: called just after a falling edge with inputs already applied.
  task automatic tick();
    #1;
    compare_outputs();
    if (acc_in_valid && acc_in_ready) obs_in.push_back({acc_in_last, acc_in_data});
    if (tx_valid && tx_ready) obs_tx.push_back(tx_data);
    @(posedge clock);
    model_step();
    @(negedge clock);
    rx_valid    = 1'b0;
    error_clear = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit silent;
    model_reset();
    reset = 1'b0;
    @(negedge clock);
    tick();
    tick();
    reset = 1'b1;

    // Basic frame.
    acc_in_ready = 1'b1;
    obs_in.delete();
    send(8'h11); send(8'h22); send(8'h33); send(8'h00);
    repeat (3) tick();
    check_eq("t1_beats", obs_in.size(), 4);
    for (int i = 0; i < 4; i++) if (i < obs_in.size()) check_eq("t1_beat", obs_in[i], exp1[i]);
    check_eq("t1_busy", busy, 1);

    // Response with transmitter stall.
    obs_tx.delete();
    acc_out_valid = 1'b1; acc_out_data = 8'hAA; acc_out_last = 1'b0; tx_ready = 1'b1; tick();
    acc_out_data = 8'hBB; acc_out_last = 1'b1; tx_ready = 1'b0; tick();
    tx_ready = 1'b1; tick();
    acc_out_valid = 1'b0; acc_out_last = 1'b0; tx_ready = 1'b0;
    check_eq("t2_tx_count", obs_tx.size(), 2);
    if (obs_tx.size() == 2) begin
      check_eq("t2_tx0", obs_tx[0], 8'hAA);
      check_eq("t2_tx1", obs_tx[1], 8'hBB);
    end
    check_eq("t2_frames", frame_count, 1);
    check_eq("t2_idle", busy, 0);

    // Overrun while the accelerator stalls.
    acc_in_ready = 1'b0;
    obs_in.delete();
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    repeat (30) send(8'h01);
    send(8'h00);
    check_eq("t3_ovr_set", error_overrun, 1);
    error_clear = 1'b1;
    tick();
    check_eq("t3_ovr_clr", error_overrun, 0);
    acc_in_ready = 1'b1; acc_out_valid = 1'b1; acc_out_last = 1'b1;
    acc_out_data = 8'h5A; tx_ready = 1'b1;
    repeat (40) tick();
    check_eq("t3_beats", obs_in.size(), 16);
    for (int i = 0; i < 4; i++) if (i < obs_in.size()) check_eq("t3_head", obs_in[i], exp3[i]);
    for (int i = 4; i < 16; i++) if (i < obs_in.size()) check_eq("t3_fill", obs_in[i][7:0], 8'h01);
    check_eq("t3_frames", frame_count, 5);
    check_eq("t3_len", error_length, 1);

    // Length truncation; remainder forms the next frame.
    error_clear = 1'b1;
    tick();
    check_eq("t4_len_clr", error_length, 0);
    obs_in.delete();
    send(8'h01); send(8'h02); send(8'h03); send(8'h04); send(8'h05); send(8'h00);
    repeat (8) tick();
    check_eq("t4_beats", obs_in.size(), 6);
    for (int i = 0; i < 6; i++) if (i < obs_in.size()) check_eq("t4_beat", obs_in[i], exp4[i]);
    check_eq("t4_len", error_length, 1);
    check_eq("t4_frames", frame_count, 7);

    // Timeout: silent accelerator for exactly TO cycles in RESPOND.
    acc_out_valid = 1'b0; acc_out_last = 1'b0;
    send(8'h42); send(8'h00);
    repeat (2) tick();
    check_eq("t5_resp", busy, 1);
    repeat (TO - 1) tick();
    check_eq("t5_before_busy", busy, 1);
    check_eq("t5_before_to", error_timeout, 0);
    tick();
    check_eq("t5_after_busy", busy, 0);
    check_eq("t5_after_to", error_timeout, 1);
    check_eq("t5_frames", frame_count, 7);
    error_clear = 1'b1;
    tick();

    // Asynchronous reset mid-frame.
    obs_in.delete();
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    check_eq("t6_pre_beats", obs_in.size(), 2);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_eq("t6_rst_valid", acc_in_valid, 0);
    check_eq("t6_rst_busy", busy, 0);
    check_eq("t6_rst_frames", frame_count, 0);
    @(negedge clock);
    tick();
    reset = 1'b1;
    obs_in.delete();
    send(8'h7F); send(8'h00);
    repeat (3) tick();
    check_eq("t6_beats", obs_in.size(), 2);
    for (int i = 0; i < 2; i++) if (i < obs_in.size()) check_eq("t6_beat", obs_in[i], exp6[i]);

    // Random traffic with periodic silent accelerator windows.
    for (int c = 0; c < 3000; c++) begin
      silent        = (c % 600) >= 480;
      rx_valid      = ($urandom_range(0, 3) == 0);
      rx_data       = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      acc_in_ready  = ($urandom_range(0, 9) < 7);
      acc_out_valid = !silent && ($urandom_range(0, 2) == 0);
      acc_out_data  = 8'($urandom);
      acc_out_last  = ($urandom_range(0, 2) == 0);
      tx_ready      = ($urandom_range(0, 4) < 3);
      error_clear   = ($urandom_range(0, 39) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
